// File: rtl/frame_render_scheduler.sv
// frame_render_scheduler: runs enabled renderer layers in index order into the back buffer, forwarding the active layer's on-screen writes.
// Ports: Clk/Reset (async, active-high); new_frame, fb_render_ack in; fb_render_done pulse out;
// fb_we/fb_coords/fb_color registered framebuffer write port, coords packed {x, y};
// layer_en/layer_start/layer_done/layer_we/layer_coords/layer_color per-layer handshake and write buses;
// active_layer, frame_cnt, overrun_cnt, timeout_flag status.
module frame_render_scheduler #(
  parameter int NUM_LAYERS    = 2,
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter int LAYER_TIMEOUT = 65535,
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int C_W           = 8
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            new_frame,
  input  logic                            fb_render_ack,
  output logic                            fb_render_done,
  output logic                            fb_we,
  output logic [X_W+Y_W-1:0]              fb_coords,
  output logic [C_W-1:0]                  fb_color,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  output logic [NUM_LAYERS-1:0]           layer_start,
  input  logic [NUM_LAYERS-1:0]           layer_done,
  input  logic [NUM_LAYERS-1:0]           layer_we,
  input  logic [NUM_LAYERS*(X_W+Y_W)-1:0] layer_coords,
  input  logic [NUM_LAYERS*C_W-1:0]       layer_color,
  output logic [1:0]                      active_layer,
  output logic [15:0]                     frame_cnt,
  output logic [7:0]                      overrun_cnt,
  output logic                            timeout_flag
);
  localparam int XY_W = X_W + Y_W;
  typedef enum logic [1:0] {IDLE, START, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [1:0] k_q, k_d, first, nxt;
  logic has_nxt, busy, wr, adv;
  logic [NUM_LAYERS-1:0] en_q, en_d;
  logic [15:0] cnt_q, cnt_d, frame_q, frame_d;
  logic [7:0] ovr_q, ovr_d;
  logic tmo_q, tmo_d, we_q, we_d;
  logic [XY_W-1:0] coords_q, coords_d, sel_xy;
  logic [C_W-1:0] color_q, color_d, sel_c;
  logic [3:0] we4, done4, ls4;
  logic [4*XY_W-1:0] lc4;
  logic [4*C_W-1:0] lcol4;
  // Per-layer buses are zero-padded to four lanes so the 2-bit layer index selects without width games.
  always_comb begin
    we4 = 4'(layer_we);
    done4 = 4'(layer_done);
    lc4 = (4*XY_W)'(layer_coords);
    lcol4 = (4*C_W)'(layer_color);
    sel_xy = lc4[k_q*XY_W +: XY_W];
    sel_c = lcol4[k_q*C_W +: C_W];
    first = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) if (layer_en[i]) first = 2'(i);
    nxt = '0;
    has_nxt = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (en_q[i] && 2'(i) > k_q) begin
        nxt = 2'(i);
        has_nxt = 1'b1;
      end
    busy = state_q == START || state_q == RUN;
    wr = busy && we4[k_q] && 32'(sel_xy[XY_W-1:Y_W]) < SCREEN_W && 32'(sel_xy[Y_W-1:0]) < SCREEN_H;
    // A done on the last allowed cycle wins over the abort, so it never raises the flag.
    adv = state_q == RUN && (done4[k_q] || cnt_q == 16'(LAYER_TIMEOUT - 1));
    ls4 = 4'b1 << k_q;
    layer_start = state_q == START ? ls4[NUM_LAYERS-1:0] : '0;
    fb_render_done = state_q == FINISH;
    active_layer = busy ? k_q : 2'd0;
    we_d = wr;
    coords_d = wr ? sel_xy : coords_q;
    color_d = wr ? sel_c : color_q;
    ovr_d = new_frame && state_q != IDLE && ovr_q != 8'hff ? ovr_q + 8'd1 : ovr_q;
    frame_d = state_q == FINISH ? frame_q + 16'd1 : frame_q;
    tmo_d = tmo_q | (adv && !done4[k_q]);
    cnt_d = state_q == RUN ? cnt_q + 16'd1 : 16'd0;
    en_d = state_q == IDLE && fb_render_ack ? layer_en : en_q;
    state_d = state_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (fb_render_ack) begin
        state_d = |layer_en ? START : FINISH;
        k_d = first;
      end
      START: state_d = RUN;
      RUN: if (adv) begin
        state_d = has_nxt ? START : FINISH;
        k_d = has_nxt ? nxt : k_q;
      end
      default: begin
        state_d = IDLE;
        k_d = 2'd0;
      end
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      k_q <= '0;
      en_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
      ovr_q <= '0;
      tmo_q <= 1'b0;
      we_q <= 1'b0;
      coords_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      en_q <= en_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      ovr_q <= ovr_d;
      tmo_q <= tmo_d;
      we_q <= we_d;
      coords_q <= coords_d;
      color_q <= color_d;
    end
  assign fb_we = we_q;
  assign fb_coords = coords_q;
  assign fb_color = color_q;
  assign frame_cnt = frame_q;
  assign overrun_cnt = ovr_q;
  assign timeout_flag = tmo_q;
endmodule

// File: tb/tb_frame_render_scheduler.sv
// tb_frame_render_scheduler: directed-vector bench for frame_render_scheduler.
module tb_frame_render_scheduler;
  localparam int XY = 20;
  logic Clk = 1'b0, Reset = 1'b1, new_frame = 1'b0, fb_render_ack = 1'b0;
  logic fb_render_done, fb_we, timeout_flag;
  logic [XY-1:0] fb_coords;
  logic [7:0] fb_color, overrun_cnt;
  logic [1:0] layer_en = '0, layer_start, layer_done = '0, layer_we = '0, active_layer;
  logic [2*XY-1:0] layer_coords = '0;
  logic [15:0] layer_color = '0, frame_cnt;
  int nvec = 0, nerr = 0;
  frame_render_scheduler #(.LAYER_TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .new_frame(new_frame), .fb_render_ack(fb_render_ack),
    .fb_render_done(fb_render_done), .fb_we(fb_we), .fb_coords(fb_coords), .fb_color(fb_color),
    .layer_en(layer_en), .layer_start(layer_start), .layer_done(layer_done), .layer_we(layer_we),
    .layer_coords(layer_coords), .layer_color(layer_color), .active_layer(active_layer),
    .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt), .timeout_flag(timeout_flag));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
    fb_render_ack = 1'b0;
    layer_done = '0;
    layer_we = '0;
  endtask
  task automatic wr(input int l, input int x, input int y, input int c);
    layer_we[l] = 1'b1;
    layer_coords[l*XY +: XY] = {10'(x), 10'(y)};
    layer_color[l*8 +: 8] = 8'(c);
  endtask
  task automatic ack(input logic [1:0] en);
    layer_en = en;
    fb_render_ack = 1'b1;
  endtask
  function automatic logic [31:0] xy(input int x, input int y);
    return 32'({10'(x), 10'(y)});
  endfunction
  initial begin
    tick;
    tick;
    chk("rst_we", fb_we, 0);
    chk("rst_done", fb_render_done, 0);
    chk("rst_start", layer_start, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_tmo", timeout_flag, 0);
    Reset = 1'b0;
    // Frame with both layers: write then done on each.
    ack(2'b11);
    tick;
    chk("t1_start0", layer_start, 2'b01);
    chk("t1_act0", active_layer, 0);
    tick;
    wr(0, 5, 5, 3);
    tick;
    chk("t1_we", fb_we, 1);
    chk("t1_xy", fb_coords, xy(5, 5));
    chk("t1_col", fb_color, 3);
    layer_done[0] = 1'b1;
    tick;
    chk("t1_start1", layer_start, 2'b10);
    chk("t1_act1", active_layer, 1);
    chk("t1_we_off", fb_we, 0);
    chk("t1_xy_hold", fb_coords, xy(5, 5));
    tick;
    layer_done[1] = 1'b1;
    tick;
    chk("t1_done", fb_render_done, 1);
    tick;
    chk("t1_done_end", fb_render_done, 0);
    chk("t1_frame", frame_cnt, 1);
    // Off-screen filter, layer 0 only.
    ack(2'b01);
    tick;
    tick;
    wr(0, 320, 0, 1);
    tick;
    chk("t2_x320", fb_we, 0);
    wr(0, 0, 240, 2);
    tick;
    chk("t2_y240", fb_we, 0);
    wr(0, 319, 239, 6);
    tick;
    chk("t2_edge_we", fb_we, 1);
    chk("t2_edge_xy", fb_coords, xy(319, 239));
    chk("t2_edge_col", fb_color, 6);
    layer_done[0] = 1'b1;
    tick;
    chk("t2_done", fb_render_done, 1);
    tick;
    chk("t2_frame", frame_cnt, 2);
    // Only layer 1 enabled, then nothing enabled.
    ack(2'b10);
    tick;
    chk("t3_start1", layer_start, 2'b10);
    chk("t3_act1", active_layer, 1);
    tick;
    layer_done[1] = 1'b1;
    tick;
    chk("t3_done", fb_render_done, 1);
    tick;
    chk("t3_frame", frame_cnt, 3);
    ack(2'b00);
    tick;
    chk("t3e_done", fb_render_done, 1);
    chk("t3e_start", layer_start, 0);
    tick;
    chk("t3e_done_end", fb_render_done, 0);
    chk("t3e_frame", frame_cnt, 4);
    // Layer 1 traffic during layer 0 is ignored; write with layer 0's done is kept.
    ack(2'b11);
    tick;
    tick;
    wr(1, 7, 7, 9);
    layer_done[1] = 1'b1;
    tick;
    chk("t4_iso_we", fb_we, 0);
    chk("t4_iso_act", active_layer, 0);
    chk("t4_iso_start", layer_start, 0);
    wr(0, 8, 9, 4);
    layer_done[0] = 1'b1;
    tick;
    chk("t4_co_we", fb_we, 1);
    chk("t4_co_xy", fb_coords, xy(8, 9));
    chk("t4_co_col", fb_color, 4);
    chk("t4_start1", layer_start, 2'b10);
    tick;
    layer_done[1] = 1'b1;
    tick;
    chk("t4_done", fb_render_done, 1);
    tick;
    chk("t4_frame", frame_cnt, 5);
    // Layer 0 never finishes: abort after 16 RUN cycles.
    ack(2'b11);
    tick;
    repeat (16) tick;
    chk("t5_pre_start", layer_start, 0);
    chk("t5_pre_tmo", timeout_flag, 0);
    tick;
    chk("t5_abort_start", layer_start, 2'b10);
    chk("t5_tmo", timeout_flag, 1);
    chk("t5_ovr0", overrun_cnt, 0);
    new_frame = 1'b1;
    repeat (10) tick;
    chk("t5_ovr10", overrun_cnt, 10);
    for (int i = 0; i < 300; i++) begin
      ack(2'b11);
      tick;
    end
    new_frame = 1'b0;
    chk("t5_ovr_sat", overrun_cnt, 255);
    for (int i = 0; i < 100 && !fb_render_done; i++) tick;
    chk("t5_drain", fb_render_done, 1);
    tick;
    chk("t5_tmo_sticky", timeout_flag, 1);
    // Asynchronous reset mid-RUN.
    ack(2'b01);
    tick;
    tick;
    wr(0, 1, 1, 1);
    tick;
    chk("t6_we_pre", fb_we, 1);
    #2 Reset = 1'b1;
    #1;
    chk("t6_we", fb_we, 0);
    chk("t6_xy", fb_coords, 0);
    chk("t6_act", active_layer, 0);
    chk("t6_tmo", timeout_flag, 0);
    chk("t6_ovr", overrun_cnt, 0);
    chk("t6_frame", frame_cnt, 0);
    tick;
    chk("t6_nodone_a", fb_render_done, 0);
    Reset = 1'b0;
    tick;
    chk("t6_nodone_b", fb_render_done, 0);
    ack(2'b01);
    tick;
    chk("t6_restart", layer_start, 2'b01);
    tick;
    layer_done[0] = 1'b1;
    tick;
    chk("t6_done", fb_render_done, 1);
    tick;
    chk("t6_frame1", frame_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
